// File: rtl/ext_unit_pipe_if.sv
// Handshake bundle for ext_unit_pipe: the operand fields, the flush strobe and both valid/ready pairs.
interface ext_unit_pipe_if #(
    parameter int DATA_W  = 32,
    parameter int IMM_W   = 16,
    parameter int SHAMT_W = 5
);
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [2:0]         mode;
    logic [IMM_W-1:0]   imm;
    logic [SHAMT_W-1:0] shamt;
    logic [DATA_W-1:0]  load_data;
    logic [1:0]         byte_off;
    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  out_data;
    logic               out_misalign;

    // master: the decode/MEM-stage side that produces operands and consumes results.
    modport master (
        output flush,
        output in_valid,
        output mode,
        output imm,
        output shamt,
        output load_data,
        output byte_off,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_misalign
    );

    // slave: the extension unit itself.
    modport slave (
        input  flush,
        input  in_valid,
        input  mode,
        input  imm,
        input  shamt,
        input  load_data,
        input  byte_off,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_misalign
    );
endinterface

// File: rtl/ext_unit_pipe.sv
// Mode-selectable immediate/shamt/load-lane extension unit.
// Results are held in a 2-entry valid/ready FIFO so pipeline stalls never drop an operand.
module ext_unit_pipe #(
    parameter int DATA_W   = 32,
    parameter int IMM_W    = 16,
    parameter int SHAMT_W  = 5,
    parameter int BR_SHIFT = 2
) (
    input  logic           clk,
    input  logic           rst,
    ext_unit_pipe_if.slave bus
);

    typedef enum logic [2:0] {
        MODE_SEXT       = 3'd0,
        MODE_ZEXT       = 3'd1,
        MODE_SEXT_SHL   = 3'd2,
        MODE_ZEXT_SHAMT = 3'd3,
        MODE_LB         = 3'd4,
        MODE_LBU        = 3'd5,
        MODE_LH         = 3'd6,
        MODE_LHU        = 3'd7
    } extMode_t;

    typedef struct packed {
        logic              misalign;
        logic [DATA_W-1:0] data;
    } bufEntry_t;

    extMode_t   curMode;
    logic       immSign;
    logic [7:0] loadByte;
    logic [15:0] loadHalf;
    bufEntry_t  extResult;

    assign curMode = extMode_t'(bus.mode);
    assign immSign = bus.imm[IMM_W-1];

    // Little-endian lane pick; only the low 32 bits of the load word carry lanes.
    always_comb begin
        // NOTE: every combinational output is given a default first so no path can infer a latch.
        loadByte = bus.load_data[7:0];
        case (bus.byte_off)
            2'd0:    loadByte = bus.load_data[7:0];
            2'd1:    loadByte = bus.load_data[15:8];
            2'd2:    loadByte = bus.load_data[23:16];
            default: loadByte = bus.load_data[31:24];
        endcase
        loadHalf = bus.byte_off[1] ? bus.load_data[31:16] : bus.load_data[15:0];
    end

    always_comb begin
        extResult = '0;
        case (curMode)
            MODE_SEXT:
                extResult.data = {{(DATA_W-IMM_W){immSign}}, bus.imm};
            MODE_ZEXT:
                extResult.data = {{(DATA_W-IMM_W){1'b0}}, bus.imm};
            MODE_SEXT_SHL:
                extResult.data = {{(DATA_W-IMM_W-BR_SHIFT){immSign}}, bus.imm, {BR_SHIFT{1'b0}}};
            MODE_ZEXT_SHAMT:
                extResult.data = {{(DATA_W-SHAMT_W){1'b0}}, bus.shamt};
            MODE_LB:
                extResult.data = {{(DATA_W-8){loadByte[7]}}, loadByte};
            MODE_LBU:
                extResult.data = {{(DATA_W-8){1'b0}}, loadByte};
            MODE_LH: begin
                extResult.data     = {{(DATA_W-16){loadHalf[15]}}, loadHalf};
                extResult.misalign = bus.byte_off[0];
            end
            MODE_LHU: begin
                extResult.data     = {{(DATA_W-16){1'b0}}, loadHalf};
                extResult.misalign = bus.byte_off[0];
            end
            default:
                extResult = '0;
        endcase
    end

    bufEntry_t  mem [2];
    bufEntry_t  lastHead;
    bufEntry_t  headEntry;
    logic       rdPtr;
    logic       wrPtr;
    logic [1:0] count;
    logic       pushEn;
    logic       popEn;

    // Ready depends only on the registered count, so out_ready never reaches in_ready.
    assign bus.in_ready  = (count != 2'd2);
    assign bus.out_valid = (count != 2'd0);
    assign pushEn        = bus.in_valid  && bus.in_ready  && !bus.flush;
    assign popEn         = bus.out_valid && bus.out_ready && !bus.flush;

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            count <= 2'd0;
            rdPtr <= 1'b0;
            wrPtr <= 1'b0;
        end else if (bus.flush) begin
            count <= 2'd0;
            rdPtr <= 1'b0;
            wrPtr <= 1'b0;
        end else begin
            if (pushEn) wrPtr <= ~wrPtr;
            if (popEn)  rdPtr <= ~rdPtr;
            case ({pushEn, popEn})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the two storage slots are reset as well, because out_data must read 0 straight out of reset.
        if (rst) begin
            mem[0]   <= '0;
            mem[1]   <= '0;
            lastHead <= '0;
        end else begin
            if (pushEn)        mem[wrPtr] <= extResult;
            if (bus.out_valid) lastHead   <= mem[rdPtr];
        end
    end

    // An empty buffer keeps showing the last delivered head instead of a stale slot.
    assign headEntry        = bus.out_valid ? mem[rdPtr] : lastHead;
    assign bus.out_data     = headEntry.data;
    assign bus.out_misalign = bus.out_valid && headEntry.misalign;

endmodule

// File: tb/tb_ext_unit_pipe.sv
// Self-checking bench for ext_unit_pipe: directed vector table, handshake corner sequences,
// and a randomized run against a queue-based reference model.
module tb_ext_unit_pipe;
    localparam int DATA_W  = 32;
    localparam int IMM_W   = 16;
    localparam int SHAMT_W = 5;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    ext_unit_pipe_if #(.DATA_W(DATA_W), .IMM_W(IMM_W), .SHAMT_W(SHAMT_W)) bus ();

    ext_unit_pipe #(
        .DATA_W  (DATA_W),
        .IMM_W   (IMM_W),
        .SHAMT_W (SHAMT_W),
        .BR_SHIFT(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  mode;
        logic [15:0] imm;
        logic [4:0]  shamt;
        logic [31:0] ld;
        logic [1:0]  off;
        logic [31:0] expData;
        logic        expMis;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic setIn(input logic [2:0] m, input logic [15:0] im, input logic [4:0] sh,
                         input logic [31:0] ld, input logic [1:0] off);
        bus.mode      = m;
        bus.imm       = im;
        bus.shamt     = sh;
        bus.load_data = ld;
        bus.byte_off  = off;
    endtask

    // Reference extension from the mode rules, using plain integer arithmetic.
    function automatic logic [32:0] refExt(input int m, input int im, input int sh,
                                           input logic [31:0] ld, input int off);
        int v;
        int lane;
        logic mis;
        mis = 1'b0;
        v   = 0;
        case (m)
            0: begin v = im; if (v >= 32768) v -= 65536; end
            1: v = im;
            2: begin v = im; if (v >= 32768) v -= 65536; v = v * 4; end
            3: v = sh;
            4, 5: begin
                lane = int'((ld >> (8 * off)) & 32'hFF);
                v = (m == 4 && lane >= 128) ? lane - 256 : lane;
            end
            default: begin
                lane = int'((ld >> (16 * (off / 2))) & 32'hFFFF);
                v = (m == 6 && lane >= 32768) ? lane - 65536 : lane;
                mis = (off % 2) == 1;
            end
        endcase
        return {mis, 32'(v)};
    endfunction

    logic [32:0] modelQ [$];

    initial begin
        logic [32:0] e;
        logic        acc;
        logic        pop;

        vecs[0]  = '{3'd0, 16'h8001, 5'h1F, 32'h0, 2'd0, 32'hFFFF8001, 1'b0};
        vecs[1]  = '{3'd1, 16'h8001, 5'h1F, 32'h0, 2'd0, 32'h00008001, 1'b0};
        vecs[2]  = '{3'd2, 16'h8001, 5'h1F, 32'h0, 2'd0, 32'hFFFE0004, 1'b0};
        vecs[3]  = '{3'd3, 16'h8001, 5'h1F, 32'h0, 2'd0, 32'h0000001F, 1'b0};
        vecs[4]  = '{3'd4, 16'h0, 5'h0, 32'h80FF7F01, 2'd0, 32'h00000001, 1'b0};
        vecs[5]  = '{3'd4, 16'h0, 5'h0, 32'h80FF7F01, 2'd1, 32'h0000007F, 1'b0};
        vecs[6]  = '{3'd4, 16'h0, 5'h0, 32'h80FF7F01, 2'd2, 32'hFFFFFFFF, 1'b0};
        vecs[7]  = '{3'd4, 16'h0, 5'h0, 32'h80FF7F01, 2'd3, 32'hFFFFFF80, 1'b0};
        vecs[8]  = '{3'd5, 16'h0, 5'h0, 32'h80FF7F01, 2'd0, 32'h00000001, 1'b0};
        vecs[9]  = '{3'd5, 16'h0, 5'h0, 32'h80FF7F01, 2'd1, 32'h0000007F, 1'b0};
        vecs[10] = '{3'd5, 16'h0, 5'h0, 32'h80FF7F01, 2'd2, 32'h000000FF, 1'b0};
        vecs[11] = '{3'd5, 16'h0, 5'h0, 32'h80FF7F01, 2'd3, 32'h00000080, 1'b0};
        vecs[12] = '{3'd6, 16'h0, 5'h0, 32'h80FF7F01, 2'd2, 32'hFFFF80FF, 1'b0};
        vecs[13] = '{3'd7, 16'h0, 5'h0, 32'h80FF7F01, 2'd0, 32'h00007F01, 1'b0};
        vecs[14] = '{3'd6, 16'h0, 5'h0, 32'h80FF7F01, 2'd1, 32'h00007F01, 1'b1};

        rst           = 1'b1;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        setIn(3'd0, 16'h0, 5'h0, 32'h0, 2'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset in_ready", 32'(bus.in_ready), 32'd1);
        check("reset out_data", bus.out_data, 32'h0);
        check("reset out_misalign", 32'(bus.out_misalign), 32'd0);

        // Fill to count=2, then assert reset mid-cycle.
        setIn(3'd1, 16'h1234, 5'h0, 32'h0, 2'd0);
        bus.in_valid = 1'b1;
        @(negedge clk);
        setIn(3'd1, 16'h5678, 5'h0, 32'h0, 2'd0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("full in_ready", 32'(bus.in_ready), 32'd0);
        check("full out_data", bus.out_data, 32'h00001234);
        #2 rst = 1'b1;
        #1;
        check("midreset out_valid", 32'(bus.out_valid), 32'd0);
        check("midreset in_ready", 32'(bus.in_ready), 32'd1);
        check("midreset out_data", bus.out_data, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors, out_ready held high: each result is at the head one cycle after accept.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            setIn(vecs[i].mode, vecs[i].imm, vecs[i].shamt, vecs[i].ld, vecs[i].off);
            bus.in_valid = 1'b1;
            @(negedge clk);
            check($sformatf("vec%0d out_valid", i), 32'(bus.out_valid), 32'd1);
            check($sformatf("vec%0d out_data", i), bus.out_data, vecs[i].expData);
            check($sformatf("vec%0d out_misalign", i), 32'(bus.out_misalign), 32'(vecs[i].expMis));
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("drain out_valid", 32'(bus.out_valid), 32'd0);

        // Backpressure: A, B accepted, C refused; then A, B delivered in order.
        bus.out_ready = 1'b0;
        setIn(3'd1, 16'h00AA, 5'h0, 32'h0, 2'd0);
        bus.in_valid = 1'b1;
        @(negedge clk);
        check("bp in_ready after A", 32'(bus.in_ready), 32'd1);
        setIn(3'd1, 16'h00BB, 5'h0, 32'h0, 2'd0);
        @(negedge clk);
        check("bp in_ready after B", 32'(bus.in_ready), 32'd0);
        setIn(3'd1, 16'h00CC, 5'h0, 32'h0, 2'd0);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        check("bp head A", bus.out_data, 32'h000000AA);
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp head B", bus.out_data, 32'h000000BB);
        check("bp B valid", 32'(bus.out_valid), 32'd1);
        @(negedge clk);
        check("bp C never accepted", 32'(bus.out_valid), 32'd0);

        // Push and pop together at count=1.
        bus.out_ready = 1'b0;
        setIn(3'd3, 16'h0, 5'h0D, 32'h0, 2'd0);
        bus.in_valid = 1'b1;
        @(negedge clk);
        check("pp head D", bus.out_data, 32'h0000000D);
        setIn(3'd3, 16'h0, 5'h0E, 32'h0, 2'd0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("pp count stays 1 (valid)", 32'(bus.out_valid), 32'd1);
        check("pp count stays 1 (ready)", 32'(bus.in_ready), 32'd1);
        check("pp head E", bus.out_data, 32'h0000000E);
        @(negedge clk);
        check("pp drained", 32'(bus.out_valid), 32'd0);

        // flush with count=2, in_valid and out_ready all active.
        bus.out_ready = 1'b0;
        setIn(3'd1, 16'h0F0F, 5'h0, 32'h0, 2'd0);
        bus.in_valid = 1'b1;
        @(negedge clk);
        setIn(3'd1, 16'h0606, 5'h0, 32'h0, 2'd0);
        @(negedge clk);
        check("fl full before flush", 32'(bus.in_ready), 32'd0);
        setIn(3'd1, 16'h0B0B, 5'h0, 32'h0, 2'd0);
        bus.flush     = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        check("fl out_valid", 32'(bus.out_valid), 32'd0);
        check("fl in_ready", 32'(bus.in_ready), 32'd1);
        check("fl out_data held", bus.out_data, 32'h00000F0F);
        repeat (2) @(negedge clk);
        check("fl input dropped", 32'(bus.out_valid), 32'd0);

        // Randomized traffic against the queue model.
        for (int c = 0; c < 1500; c++) begin
            check("rnd out_valid", 32'(bus.out_valid), 32'(modelQ.size() != 0));
            check("rnd in_ready", 32'(bus.in_ready), 32'(modelQ.size() != 2));
            if (modelQ.size() != 0) begin
                check("rnd out_data", bus.out_data, modelQ[0][31:0]);
                check("rnd out_misalign", 32'(bus.out_misalign), 32'(modelQ[0][32]));
            end
            setIn(3'($urandom_range(0, 7)), 16'($urandom), 5'($urandom), 32'($urandom),
                  2'($urandom_range(0, 3)));
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            bus.out_ready = ($urandom_range(0, 9) < 6);
            bus.flush     = ($urandom_range(0, 15) == 0);
            acc = bus.in_valid && (modelQ.size() != 2) && !bus.flush;
            pop = (modelQ.size() != 0) && bus.out_ready && !bus.flush;
            e   = refExt(int'(bus.mode), int'(bus.imm), int'(bus.shamt), bus.load_data,
                         int'(bus.byte_off));
            @(posedge clk);
            if (bus.flush) modelQ.delete();
            else begin
                if (pop) void'(modelQ.pop_front());
                if (acc) modelQ.push_back(e);
            end
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ext_unit_pipe.md
Name: ext_unit_pipe

Overview:
- Registered, mode-selectable extension unit for the 54-instruction pipelined CPU.
- Generalises immediate/shamt extension with these additions:
  - parametrised input widths
  - a branch-offset shift
  - LB/LBU/LH/LHU load-data lane selection
  - a misalignment flag
- Results pass through a 2-entry valid/ready buffer, so ID/MEM stalls do not lose extended operands.
- Sits between decode (or the MEM data port) and the next pipeline register.

Parameters:
- DATA_W, 32: output and load-data width; must be a multiple of 16.
- IMM_W, 16: immediate input width; must be less than DATA_W-2.
- SHAMT_W, 5: shift-amount input width.
- BR_SHIFT, 2: left shift applied in mode SEXT_SHL.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; asynchronous, active-high.
- flush  in  1  synchronous; discards buffered entries and the current input.
- in_valid  in  1  input operand valid.
- in_ready  out  1  unit can accept an input this cycle.
- mode  in  3  operation select; values listed in Behaviour.
- imm  in  IMM_W  immediate field.
- shamt  in  SHAMT_W  shift-amount field.
- load_data  in  DATA_W  raw word read from data memory.
- byte_off  in  2  address[1:0] of the load.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer accepts the head entry.
- out_data  out  DATA_W  extended result.
- out_misalign  out  1  head entry is a halfword load with byte_off[0]=1.

Behaviour:
- Modes:
  - 0 SEXT: imm sign-extended to DATA_W.
  - 1 ZEXT: imm zero-extended.
  - 2 SEXT_SHL: imm sign-extended, then shifted left BR_SHIFT; low BR_SHIFT bits are 0; the upper (DATA_W-IMM_W-BR_SHIFT) bits copy imm[IMM_W-1].
  - 3 ZEXT_SHAMT: shamt zero-extended.
  - 4 LB: byte = load_data[8*byte_off +: 8], sign-extended.
  - 5 LBU: same byte, zero-extended.
  - 6 LH: half = load_data[16*byte_off[1] +: 16], sign-extended.
  - 7 LHU: same half, zero-extended.
- Little-endian lane selection. byte_off is ignored in modes 0-3.
- Misalignment:
  - out_misalign=1 only for modes 6/7 with byte_off[0]=1.
  - The data is still computed using byte_off[1] and the entry is still delivered; trapping is left to the consumer.
- Extension is combinational on the inputs; the result and flag are written into the buffer on accept.
- Accept: in_valid && in_ready && !flush.
- Buffer:
  - 2-entry FIFO, count in {0,1,2}.
  - in_ready = (count != 2), decoded from the registered count only; no combinational path from out_ready.
- Head / pop:
  - out_valid = (count != 0).
  - out_data and out_misalign come from the head entry.
  - Pop: out_valid && out_ready && !flush.
- Latency and throughput:
  - An accepted input appears at the head 1 cycle later, when the buffer was empty or the prior entry popped.
  - With out_ready held high, throughput is 1 per cycle.
- Simultaneous push and pop at count=1: count stays 1 and the new entry becomes head next cycle.
- Push at count=0 with out_ready=1: no pop that cycle, because out_valid=0.
- count=2: in_ready=0; a pop that cycle frees a slot visible next cycle.
- Ordering is strictly FIFO; entries are never reordered or duplicated.
- Pointers: 1-bit read and write pointers wrap 1→0.
- flush: at the next edge, count=0 and both pointers=0. Same-cycle inputs are dropped and no pop is counted. flush takes priority over push and pop.
- Reset (asynchronous assert, async or sync deassert irrelevant):
  - count=0, pointers=0, out_valid=0, in_ready=1.
  - out_data=0 and out_misalign=0 (storage cleared).
  - Reset mid-operation loses all entries.
- When out_valid=0, out_data is don't-care for the consumer but is held at its last head value; no X propagation.

Test Plan:
- Reset mid-stream with count=2 → same-cycle out_valid=0, in_ready=1, out_data=0. After release, modes 0-3 (one per cycle, out_ready=1), imm=16'h8001 and shamt=5'h1F, give 32'hFFFF8001, 32'h00008001, 32'hFFFE0004 and 32'h0000001F, each 1 cycle after accept.
- load_data=32'h80FF7F01, byte_off 0..3 in LB → 32'h00000001, 32'h0000007F, 32'hFFFFFFFF, 32'hFFFFFF80. Same sweep in LBU → 32'h01, 32'h7F, 32'hFF, 32'h80.
- Halfword loads, same load_data:
  - LH with byte_off=2 → 32'hFFFF80FF, misalign=0.
  - LHU with byte_off=0 → 32'h00007F01.
  - LH with byte_off=1 → data 32'h00007F01, out_misalign=1.
- Backpressure: out_ready=0, push A, B, C back-to-back → in_ready drops after B, C is not accepted. Then raise out_ready → A then B delivered, in order, on consecutive cycles.
- Simultaneous events:
  - At count=1, push and pop in one cycle → count stays 1 and order is preserved.
  - flush asserted together with in_valid, out_ready and count=2 → next cycle count=0 and the flushed input never appears.
